// File: rtl/draw_pkg.sv
//------------------------------------------------------------------------------
// Module  : draw_pkg
// Purpose : Shared encodings for the frame draw scheduler.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package draw_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;

  localparam int CL_PLAT  = 0;
  localparam int CL_BALL  = 1;
  localparam int CL_BRICK = 2;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_MOVE  = 3'd4
  } sched_state_t;

  typedef enum logic {
    PASS_ERASE = 1'b0,
    PASS_DRAW  = 1'b1
  } pass_t;

endpackage

`default_nettype wire

// File: rtl/draw_scheduler_if.sv
//------------------------------------------------------------------------------
// Module  : draw_scheduler_if
// Purpose : Client-side draw bus and muxed VGA write port of the scheduler.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface draw_scheduler_if #(
  parameter int NCLIENT = 3
);
  import draw_pkg::*;

  logic [NCLIENT-1:0]          client_en;
  logic [NCLIENT-1:0]          cl_done;
  logic [NCLIENT-1:0]          cl_wren;
  logic [COORD_W*NCLIENT-1:0]  cl_x;
  logic [COORD_W*NCLIENT-1:0]  cl_y;
  logic [COLOUR_W*NCLIENT-1:0] cl_colour;
  logic [NCLIENT-1:0]          cl_start;
  logic [COORD_W-1:0]          vga_x;
  logic [COORD_W-1:0]          vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_wren;

  modport master (
    input  client_en, cl_done, cl_wren, cl_x, cl_y, cl_colour,
    output cl_start, vga_x, vga_y, vga_colour, vga_wren
  );

  modport slave (
    output client_en, cl_done, cl_wren, cl_x, cl_y, cl_colour,
    input  cl_start, vga_x, vga_y, vga_colour, vga_wren
  );

endinterface

`default_nettype wire

// File: rtl/frame_tick_gen.sv
//------------------------------------------------------------------------------
// Module  : frame_tick_gen
// Purpose : Free-running frame counter; tick marks the last cycle of a frame.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  wire logic clk,
  input  wire logic resetn,
  output logic      tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_cnt <= '0;
    else if (r_cnt == C_LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/draw_scheduler.sv
//------------------------------------------------------------------------------
// Module  : draw_scheduler
// Purpose : Shares the VGA write port between drawing clients, running an
//           ERASE pass, a move strobe and a DRAW pass once per frame.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NCLIENT      = 3,
  parameter int FRAME_CYCLES = 833333,
  parameter int TIMEOUT      = 65536
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  draw_scheduler_if.master  bus,
  output logic              move_en,
  output logic              busy,
  output logic              frame_overrun,
  output logic              timeout_err
);

  localparam int IDX_W = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NCLIENT - 1);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_t        r_state, w_state_nxt;
  pass_t               r_pass, w_pass_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [TMR_W-1:0]    r_timer, w_timer_nxt;
  logic                r_overrun, r_timeout;
  logic                w_tick, w_to_set, w_move, w_in_wait;
  logic [NCLIENT-1:0]  w_start;

  logic                w_sel_en, w_sel_done, w_sel_wren;
  logic [COORD_W-1:0]  w_sel_x, w_sel_y;
  logic [COLOUR_W-1:0] w_sel_col;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (w_tick)
  );

  // Fields of the currently selected client
  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_done = 1'b0;
    w_sel_wren = 1'b0;
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_col  = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_en   = bus.client_en[i];
        w_sel_done = bus.cl_done[i];
        w_sel_wren = bus.cl_wren[i];
        w_sel_x    = bus.cl_x[i*COORD_W +: COORD_W];
        w_sel_y    = bus.cl_y[i*COORD_W +: COORD_W];
        w_sel_col  = bus.cl_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_to_set    = 1'b0;
    w_move      = 1'b0;
    w_start     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_nxt = ST_START;
          w_idx_nxt   = '0;
          w_pass_nxt  = PASS_ERASE;
        end
      end
      ST_START: begin
        w_timer_nxt = '0;
        if (w_sel_en) begin
          w_start     = NCLIENT'(1) << r_idx;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_NEXT;
        end
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        // A done arriving on the last allowed cycle still counts as on time
        if (w_sel_done) begin
          w_state_nxt = ST_NEXT;
        end else if (r_timer == C_TMR_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_idx != C_IDX_LAST) begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = ST_START;
        end else if (r_pass == PASS_ERASE) begin
          w_state_nxt = ST_MOVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE: begin
        w_move      = 1'b1;
        w_pass_nxt  = PASS_DRAW;
        w_idx_nxt   = '0;
        w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_pass    <= PASS_ERASE;
      r_idx     <= '0;
      r_timer   <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pass  <= w_pass_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      if (w_tick && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      if (w_to_set)
        r_timeout <= 1'b1;
    end
  end

  assign w_in_wait      = (r_state == ST_WAIT);
  assign bus.cl_start   = w_start;
  assign bus.vga_wren   = w_in_wait & w_sel_wren;
  assign bus.vga_x      = w_in_wait ? w_sel_x : '0;
  assign bus.vga_y      = w_in_wait ? w_sel_y : '0;
  assign bus.vga_colour = (w_in_wait && (r_pass == PASS_DRAW)) ? w_sel_col : COLOUR_BLACK;
  assign move_en        = w_move;
  assign busy           = (r_state != ST_IDLE);
  assign frame_overrun  = r_overrun;
  assign timeout_err    = r_timeout;

endmodule

`default_nettype wire
